// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs for ALU/LSB, round-robin CDB broadcast.
// Define CDB_PERF_EN to add grant and conflict performance counters.
`ifndef ROB_BIT
`define ROB_BIT 4
`endif

module cdb_arbiter #(
    parameter int ROB_BIT    = `ROB_BIT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               alu_valid,
    input  logic [ROB_BIT-1:0] alu_rob_entry,
    input  logic [31:0]        alu_value,
    output logic               alu_ready,
    input  logic               lsb_valid,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    output logic               lsb_ready,
    output logic               cdb_valid,
    output logic [ROB_BIT-1:0] cdb_rob_entry,
    output logic [31:0]        cdb_value,
    output logic               cdb_src
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]        perf_alu_grants,
    output logic [31:0]        perf_lsb_grants,
    output logic [31:0]        perf_conflict_cycles
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [ROB_BIT-1:0] ent_mem [2][FIFO_DEPTH];
    logic [31:0]        val_mem [2][FIFO_DEPTH];

    logic [PW-1:0] rd_q  [2];
    logic [PW-1:0] rd_d  [2];
    logic [PW-1:0] wr_q  [2];
    logic [PW-1:0] wr_d  [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic               last_q, last_d;
    logic               vld_q, vld_d;
    logic               src_q, src_d;
    logic [ROB_BIT-1:0] ent_q, ent_d;
    logic [31:0]        val_q, val_d;

    logic [ROB_BIT-1:0] in_ent [2];
    logic [31:0]        in_val [2];
    logic [1:0]         in_vld, rdy, ne, push, pop;
    logic               gnt_vld, gnt_src, act, flush;

    assign in_vld    = {lsb_valid, alu_valid};
    assign in_ent[0] = alu_rob_entry;
    assign in_ent[1] = lsb_rob_entry;
    assign in_val[0] = alu_value;
    assign in_val[1] = lsb_value;

    assign act   = rdy_in & ~rob_clear_up;
    assign flush = rdy_in & rob_clear_up;

    assign ne  = {cnt_q[1] != '0, cnt_q[0] != '0};
    assign rdy = {cnt_q[1] != FULL, cnt_q[0] != FULL};

    // With both heads valid, the source that did not win last time goes.
    assign gnt_vld = ne[0] | ne[1];
    assign gnt_src = (ne[0] & ne[1]) ? ~last_q : ne[1];

    assign push = {2{act}} & in_vld & rdy;
    assign pop  = (act & gnt_vld) ? {gnt_src, ~gnt_src} : 2'b00;

    assign alu_ready     = rdy[0];
    assign lsb_ready     = rdy[1];
    assign cdb_valid     = vld_q;
    assign cdb_rob_entry = ent_q;
    assign cdb_value     = val_q;
    assign cdb_src       = src_q;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            rd_d[s]  = rd_q[s];
            wr_d[s]  = wr_q[s];
            cnt_d[s] = cnt_q[s];
            if (flush) begin
                rd_d[s]  = '0;
                wr_d[s]  = '0;
                cnt_d[s] = '0;
            end else begin
                if (push[s]) wr_d[s] = wr_q[s] + PW'(1);
                if (pop[s])  rd_d[s] = rd_q[s] + PW'(1);
                cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    always_comb begin
        last_d = last_q;
        vld_d  = vld_q;
        src_d  = src_q;
        ent_d  = ent_q;
        val_d  = val_q;
        if (flush) begin
            vld_d  = 1'b0;
            last_d = 1'b1;
        end else if (act) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                src_d  = gnt_src;
                last_d = gnt_src;
                ent_d  = ent_mem[gnt_src][rd_q[gnt_src]];
                val_d  = val_mem[gnt_src][rd_q[gnt_src]];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < 2; s++) begin
                rd_q[s]  <= '0;
                wr_q[s]  <= '0;
                cnt_q[s] <= '0;
            end
            last_q <= 1'b1;
            vld_q  <= 1'b0;
            src_q  <= 1'b0;
            ent_q  <= '0;
            val_q  <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                rd_q[s]  <= rd_d[s];
                wr_q[s]  <= wr_d[s];
                cnt_q[s] <= cnt_d[s];
            end
            last_q <= last_d;
            vld_q  <= vld_d;
            src_q  <= src_d;
            ent_q  <= ent_d;
            val_q  <= val_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                ent_mem[s][wr_q[s]] <= in_ent[s];
                val_mem[s][wr_q[s]] <= in_val[s];
            end
        end
    end

`ifdef CDB_PERF_EN
    logic [31:0] pa_q, pa_d, pl_q, pl_d, pc_q, pc_d;

    always_comb begin
        pa_d = pa_q;
        pl_d = pl_q;
        pc_d = pc_q;
        if (pop[0]) pa_d = pa_q + 32'd1;
        if (pop[1]) pl_d = pl_q + 32'd1;
        if (act && (&ne)) pc_d = pc_q + 32'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pa_q <= '0;
            pl_q <= '0;
            pc_q <= '0;
        end else begin
            pa_q <= pa_d;
            pl_q <= pl_d;
            pc_q <= pc_d;
        end
    end

    assign perf_alu_grants      = pa_q;
    assign perf_lsb_grants      = pl_q;
    assign perf_conflict_cycles = pc_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: queue-based reference model feeding a scoreboard;
// a negedge monitor compares every post-edge output state.
module tb_cdb_arbiter;

    localparam int RB = 4;
    localparam int D  = 2;

    typedef struct packed {
        logic          vld;
        logic [RB-1:0] ent;
        logic [31:0]   val;
        logic          src;
        logic          ar;
        logic          lr;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in = 1'b1;
    logic          rob_clear_up = 1'b0;
    logic          alu_valid = 1'b0;
    logic [RB-1:0] alu_rob_entry = '0;
    logic [31:0]   alu_value = '0;
    logic          lsb_valid = 1'b0;
    logic [RB-1:0] lsb_rob_entry = '0;
    logic [31:0]   lsb_value = '0;
    logic          alu_ready, lsb_ready, cdb_valid, cdb_src;
    logic [RB-1:0] cdb_rob_entry;
    logic [31:0]   cdb_value;
`ifdef CDB_PERF_EN
    logic [31:0]   perf_alu_grants, perf_lsb_grants, perf_conflict_cycles;
`endif

    cdb_arbiter #(.ROB_BIT(RB), .FIFO_DEPTH(D)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_clear_up  (rob_clear_up),
        .alu_valid     (alu_valid),
        .alu_rob_entry (alu_rob_entry),
        .alu_value     (alu_value),
        .alu_ready     (alu_ready),
        .lsb_valid     (lsb_valid),
        .lsb_rob_entry (lsb_rob_entry),
        .lsb_value     (lsb_value),
        .lsb_ready     (lsb_ready),
        .cdb_valid     (cdb_valid),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_value     (cdb_value),
        .cdb_src       (cdb_src)
`ifdef CDB_PERF_EN
        ,
        .perf_alu_grants      (perf_alu_grants),
        .perf_lsb_grants      (perf_lsb_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    always #5 clk_in = ~clk_in;

    exp_t           exp_q [$];
    logic [RB+31:0] qa [$];
    logic [RB+31:0] ql [$];
    logic           m_vld, m_src, m_last;
    logic [RB-1:0]  m_ent;
    logic [31:0]    m_val;
    int             n_chk = 0;
    int             n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, got, req, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        ql.delete();
        exp_q.delete();
        m_vld  = 1'b0;
        m_src  = 1'b0;
        m_last = 1'b1;
        m_ent  = '0;
        m_val  = '0;
    endtask

    // Drive one cycle, advance the model across the coming edge, queue the expectation.
    task automatic step(input logic av, input logic [RB-1:0] ae, input logic [31:0] aval,
                        input logic lv, input logic [RB-1:0] le, input logic [31:0] lval,
                        input logic fl, input logic rd);
        logic           acc_a, acc_l, g;
        logic [RB+31:0] it;
        alu_valid     = av;
        alu_rob_entry = ae;
        alu_value     = aval;
        lsb_valid     = lv;
        lsb_rob_entry = le;
        lsb_value     = lval;
        rob_clear_up  = fl;
        rdy_in        = rd;
        if (rd && fl) begin
            qa.delete();
            ql.delete();
            m_vld  = 1'b0;
            m_last = 1'b1;
        end else if (rd) begin
            acc_a = av && (qa.size() < D);
            acc_l = lv && (ql.size() < D);
            if (qa.size() != 0 || ql.size() != 0) begin
                if (qa.size() != 0 && ql.size() != 0) g = ~m_last;
                else g = (ql.size() != 0);
                it     = g ? ql.pop_front() : qa.pop_front();
                m_vld  = 1'b1;
                m_src  = g;
                m_last = g;
                m_ent  = it[RB+31:32];
                m_val  = it[31:0];
            end else begin
                m_vld = 1'b0;
            end
            if (acc_a) qa.push_back({ae, aval});
            if (acc_l) ql.push_back({le, lval});
        end
        exp_q.push_back('{m_vld, m_ent, m_val, m_src, qa.size() < D, ql.size() < D});
        @(negedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " cdb_valid"}, 32'(cdb_valid), 32'd0);
        chk({tag, " alu_ready"}, 32'(alu_ready), 32'd1);
        chk({tag, " lsb_ready"}, 32'(lsb_ready), 32'd1);
`ifdef CDB_PERF_EN
        chk({tag, " perf_alu"}, perf_alu_grants, 32'd0);
        chk({tag, " perf_lsb"}, perf_lsb_grants, 32'd0);
        chk({tag, " perf_conf"}, perf_conflict_cycles, 32'd0);
`endif
    endtask

    // Reset raised between edges: effects must be visible before any clock edge.
    task automatic async_reset();
        alu_valid    = 1'b0;
        lsb_valid    = 1'b0;
        rob_clear_up = 1'b0;
        rdy_in       = 1'b1;
        #1 rst_in = 1'b1;
        #1;
        check_reset_state("async");
        model_reset();
        @(negedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (!rst_in && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cdb_valid", 32'(cdb_valid), 32'(e.vld));
            chk("cdb_rob_entry", 32'(cdb_rob_entry), 32'(e.ent));
            chk("cdb_value", cdb_value, e.val);
            chk("cdb_src", 32'(cdb_src), 32'(e.src));
            chk("alu_ready", 32'(alu_ready), 32'(e.ar));
            chk("lsb_ready", 32'(lsb_ready), 32'(e.lr));
        end
    end

    initial begin
        rst_in = 1'b0;
        model_reset();
        #1 rst_in = 1'b1;
        #1;
        check_reset_state("reset");
        chk("reset cdb_rob_entry", 32'(cdb_rob_entry), 32'd0);
        chk("reset cdb_value", cdb_value, 32'd0);
        chk("reset cdb_src", 32'(cdb_src), 32'd0);
        @(negedge clk_in);
        #1 rst_in = 1'b0;

        // single ALU result
        step(1, 4'd3, 32'hDEADBEEF, 0, '0, '0, 0, 1);
        idle(4);

        // same-cycle conflict
        step(1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 0, 1);
        idle(4);

        // LSB backpressure with ALU kept busy
        step(1, 4'd7, 32'hA7, 1, 4'd4, 32'h44, 0, 1);
        step(1, 4'd8, 32'hA8, 1, 4'd5, 32'h55, 0, 1);
        for (int k = 0; k < 10; k++) begin
            automatic bit ok = (ql.size() < D);
            step(1, RB'(9 + k), 32'hB0 + 32'(k), 1, 4'd6, 32'h66, 0, 1);
            if (ok) break;
        end
        idle(6);

        // flush with a simultaneous ALU push
        for (int k = 0; k < 3; k++)
            step(1, RB'(k), 32'hC0 + 32'(k), 1, RB'(k + 8), 32'hD0 + 32'(k), 0, 1);
        step(1, 4'hF, 32'hBAD, 1, 4'hE, 32'hBAD, 1, 1);
        idle(3);
        step(1, 4'd5, 32'h1234, 0, '0, '0, 0, 1);
        idle(3);

        // pause while busy
        for (int k = 0; k < 3; k++)
            step(1, RB'(k), 32'hE0 + 32'(k), 1, RB'(k + 4), 32'hF0 + 32'(k), 0, 1);
        for (int k = 0; k < 3; k++)
            step(1, 4'hA, 32'h999, 1, 4'hB, 32'h888, 1, 0);
        idle(5);

        // asynchronous reset with both FIFOs full
        for (int k = 0; k < 4; k++)
            step(1, RB'(k), 32'h100 + 32'(k), 1, RB'(k + 4), 32'h200 + 32'(k), 0, 1);
        async_reset();
        idle(2);
        step(1, 4'd2, 32'hCAFE, 1, 4'd3, 32'hF00D, 0, 1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) async_reset();
            step(1'($urandom_range(0, 1)), RB'($urandom), $urandom,
                 1'($urandom_range(0, 1)), RB'($urandom), $urandom,
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) != 0));
        end
        idle(5);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the ALU and the load/store buffer (LSB). It buffers each unit's finished result in a small per-source FIFO and broadcasts at most one result per cycle to the ROB and reservation stations, using round-robin arbitration. It also empties all buffered results on a ROB flush. It sits between the execution units and the ROB, upstream of the register-file commit path.

## Interface
- `ROB_BIT`, default `` `ROB_BIT `` (4): width of a ROB entry index.
- `FIFO_DEPTH`, default 2: entries per source FIFO. Must be a power of 2 and at least 2.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: pause. When low, all state is frozen.
- `rob_clear_up` in 1: flush (mispredict). Discards all buffered and in-flight results.
- `alu_valid` in 1: ALU result offered this cycle.
- `alu_rob_entry` in ROB_BIT: destination ROB entry of the ALU result.
- `alu_value` in 32: ALU result value.
- `alu_ready` out 1: ALU FIFO can accept a result.
- `lsb_valid`, `lsb_rob_entry`, `lsb_value`, `lsb_ready`: same as the ALU ports, for the LSB.
- `cdb_valid` out 1: broadcast valid.
- `cdb_rob_entry` out ROB_BIT: ROB entry being broadcast.
- `cdb_value` out 32: value being broadcast.
- `cdb_src` out 1: source of the broadcast, 0 = ALU, 1 = LSB.

## Operation
- **Push.** A source pushes on a clock edge when `rdy_in & !rob_clear_up & X_valid & X_ready`.
  - `X_ready = (count_X != FIFO_DEPTH)`. It is computed from registered state only.
  - Offering `X_valid` while `X_ready` is 0 is a protocol error. The result is dropped.
- **Arbitration.** A combinational grant is computed from the two FIFO heads.
  - Both FIFOs empty: no grant.
  - Only one FIFO non-empty: that FIFO is granted.
  - Both FIFOs non-empty: grant the source opposite to `last_grant`.
- **Pop.** On an edge with `rdy_in` high and no flush, the granted head is popped. The same edge:
  - loads it into the output registers,
  - sets `cdb_valid` to 1 and `cdb_src` to the granted source,
  - sets `last_grant` to the granted source.
- **No grant.** On an edge with no grant, `cdb_valid` is set to 0. `cdb_rob_entry` and `cdb_value` hold their previous values.
- **Simultaneous push and pop** on the same FIFO: both happen and the count is unchanged. A push into a full FIFO is impossible because `ready` is low.
- **Ordering.** Results from the same source are broadcast in arrival order. No ordering is guaranteed across the two sources.
- **Flush.** `rob_clear_up` high with `rdy_in` high, on an edge:
  - both FIFOs are emptied (pointers and counts set to 0),
  - `cdb_valid` is set to 0 and `last_grant` is set to 1,
  - any push offered in that same cycle is discarded.
- **Pause.** `rdy_in` low: no push, no pop, no flush. Outputs hold their values, including `cdb_valid`.
- **Reset** (asynchronous, immediate):
  - FIFOs empty,
  - `cdb_valid` = 0, `cdb_rob_entry` = 0, `cdb_value` = 0, `cdb_src` = 0,
  - `last_grant` = 1, so the ALU wins first,
  - `alu_ready` = 1 and `lsb_ready` = 1.
  - Assertion mid-operation discards all pending results.

## Timing
- **Latency.** A result pushed at the edge ending cycle N reaches the head in cycle N+1. If granted in N+1, it is on the CDB in cycle N+2.
- **Throughput.** One broadcast per cycle.
- **Fairness.** With both sources continuously non-empty, grants strictly alternate.
- **Ready timing.** `X_ready` updates on the edge following a push or pop. A FIFO that becomes full drops `ready` in the next cycle.
- **Flush timing.**
  - `cdb_valid` is 0 in the cycle after a flush edge.
  - Both `ready` outputs are 1 in that cycle.
  - A broadcast visible during the flush cycle itself is the consumer's responsibility to ignore.

## Configuration
- **`CDB_PERF_EN` defined:** adds three 32-bit output ports, all reset to 0 and frozen while `rdy_in` is low.
  - `perf_alu_grants`: number of ALU grants.
  - `perf_lsb_grants`: number of LSB grants.
  - `perf_conflict_cycles`: edges on which both FIFOs were non-empty.
  - All three counters wrap modulo 2^32 and are not cleared by a flush.
- **`CDB_PERF_EN` undefined:** the ports and counters are absent. Functional behaviour is identical.

## Test plan
- **Single ALU result.** After reset, `alu_valid` for 1 cycle with entry 3 and value 0xDEADBEEF. Required: `cdb_valid`=1 exactly 2 cycles later with entry 3, value 0xDEADBEEF, src 0. Then `cdb_valid`=0.
- **Conflict.** ALU (entry 1, 0x11) and LSB (entry 2, 0x22) push in the same cycle. Required: ALU is broadcast first, LSB on the next cycle, no gap between them.
- **Backpressure.** LSB pushes entries 4, 5 and 6 on consecutive cycles while the ALU FIFO is kept non-empty.
  - `lsb_ready` drops after the second push.
  - The third push is retried once `lsb_ready` returns.
  - Broadcast order for the LSB is 4, 5, 6, interleaved ALU/LSB.
- **Flush.** Fill both FIFOs to 2, then assert `rob_clear_up` for 1 cycle together with a new ALU push. Required:
  - `cdb_valid`=0 from the next cycle onward,
  - nothing further is broadcast,
  - both `ready` outputs are 1,
  - a subsequent ALU push is granted first.
- **Pause.** Hold `rdy_in` low for 3 cycles while a broadcast is visible and both FIFOs are non-empty. Required: all outputs are held, nothing is lost, and the sequence resumes unchanged.
- **Asynchronous reset mid-stream.** Assert `rst_in` between clock edges with both FIFOs full. Required: `cdb_valid`=0 and both `ready`=1 immediately, without waiting for an edge. With `CDB_PERF_EN` defined, all counters read 0.
